pc_sequencer: RTL and testbench

//  Multicycle control FSM for the OTTER-style RISC-V core. Sequences the program counter

---
 rtl/otter_pkg.sv | 41 ++++
 rtl/pc_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared types for the OTTER multicycle control path.
// Opcodes, next-PC selects, trap causes and sequencer states.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    PC4    = 3'd0,
    JALR   = 3'd1,
    BRANCH = 3'd2,
    JAL    = 3'd3,
    MTVEC  = 3'd4,
    MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_INTR    = 2'd1,
    CAUSE_ILLEGAL = 2'd2,
    CAUSE_BUS     = 2'd3
  } cause_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM_WAIT,
    S_TRAP
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute/memory/trap sequencer for the OTTER core.
// Outputs decode from state and inputs; state, wait count and cause are flops.
module pc_sequencer
  import otter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic       BR_TAKEN,
  input  logic       INTR,
  input  logic       MIE,
  input  logic       IMEM_VALID,
  input  logic       DMEM_VALID,
  output logic       IMEM_REQ,
  output logic       IR_WRITE,
  output logic       PC_WRITE,
  output logic [2:0] PC_SOURCE,
  output logic       DMEM_RDEN,
  output logic       DMEM_WE,
  output logic       RF_WE,
  output logic       CSR_WE,
  output logic       TRAP_TAKEN,
  output logic [1:0] CAUSE
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cause_t        cause_q, cause_d;

  logic    imem_req, ir_write, pc_write;
  logic    dmem_rden, dmem_we, rf_we, csr_we;
  logic    trap_taken, done;
  pc_src_t src;
  cause_t  cause_o;

  logic op_alu, op_jal, op_jalr, op_br;
  logic op_mret, op_csr, op_ld, op_st;
  logic expired;
  logic [CW-1:0] cnt_inc;

  assign op_alu  = (OPCODE == OPC_OP) || (OPCODE == OPC_OP_IMM)
                || (OPCODE == OPC_LUI) || (OPCODE == OPC_AUIPC);
  assign op_jal  = (OPCODE == OPC_JAL);
  assign op_jalr = (OPCODE == OPC_JALR);
  assign op_br   = (OPCODE == OPC_BRANCH);
  assign op_mret = (OPCODE == OPC_SYSTEM) && (FUNCT3 == 3'b000);
  assign op_csr  = (OPCODE == OPC_SYSTEM) && (FUNCT3 != 3'b000);
  assign op_ld   = (OPCODE == OPC_LOAD);
  assign op_st   = (OPCODE == OPC_STORE);

  assign expired = (cnt_q == CNT_MAX);
  assign cnt_inc = expired ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    src        = PC4;
    dmem_rden  = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    csr_we     = 1'b0;
    trap_taken = 1'b0;
    cause_o    = CAUSE_NONE;
    done       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (IMEM_VALID) begin
          imem_req = 1'b1;
          ir_write = 1'b1;
          state_d  = S_EXEC;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          imem_req = 1'b1;
          cnt_d    = cnt_inc;
        end
      end

      S_EXEC: begin
        unique case (1'b1)
          op_alu: begin
            rf_we = 1'b1;
            done  = 1'b1;
          end
          op_jal: begin
            rf_we = 1'b1;
            src   = JAL;
            done  = 1'b1;
          end
          op_jalr: begin
            rf_we = 1'b1;
            src   = JALR;
            done  = 1'b1;
          end
          op_br: begin
            src  = BR_TAKEN ? BRANCH : PC4;
            done = 1'b1;
          end
          op_mret: begin
            src  = MEPC;
            done = 1'b1;
          end
          op_csr: begin
            csr_we = 1'b1;
            rf_we  = 1'b1;
            done   = 1'b1;
          end
          op_ld: begin
            dmem_rden = 1'b1;
            state_d   = S_MEM_WAIT;
          end
          op_st: begin
            dmem_we = 1'b1;
            state_d = S_MEM_WAIT;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM_WAIT: begin
        if (DMEM_VALID) begin
          dmem_rden = op_ld;
          dmem_we   = op_st;
          rf_we     = op_ld;
          done      = 1'b1;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          dmem_rden = op_ld;
          dmem_we   = op_st;
          cnt_d     = cnt_inc;
        end
      end

      S_TRAP: begin
        pc_write   = 1'b1;
        src        = MTVEC;
        trap_taken = 1'b1;
        cause_o    = cause_q;
        state_d    = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // interrupts are only honoured at an instruction boundary
    if (done) begin
      pc_write = 1'b1;
      if (INTR && MIE) begin
        state_d = S_TRAP;
        cause_d = CAUSE_INTR;
      end else begin
        state_d = S_FETCH;
      end
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign IMEM_REQ   = RESET_N & imem_req;
  assign IR_WRITE   = RESET_N & ir_write;
  assign PC_WRITE   = RESET_N & pc_write;
  assign PC_SOURCE  = RESET_N ? src : 3'd0;
  assign DMEM_RDEN  = RESET_N & dmem_rden;
  assign DMEM_WE    = RESET_N & dmem_we;
  assign RF_WE      = RESET_N & rf_we;
  assign CSR_WE     = RESET_N & csr_we;
  assign TRAP_TAKEN = RESET_N & trap_taken;
  assign CAUSE      = RESET_N ? cause_o : 2'd0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer.
// Expected traces are built per instruction from latency and opcode.
module tb_pc_sequencer;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       br_taken = 1'b0;
  logic       intr = 1'b0;
  logic       mie = 1'b0;
  logic       imem_valid = 1'b0;
  logic       dmem_valid = 1'b0;
  logic       imem_req, ir_write, pc_write;
  logic [2:0] pc_source;
  logic       dmem_rden, dmem_we, rf_we, csr_we;
  logic       trap_taken;
  logic [1:0] cause;
  logic [12:0] obs;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .OPCODE(opcode), .FUNCT3(funct3),
    .BR_TAKEN(br_taken), .INTR(intr), .MIE(mie),
    .IMEM_VALID(imem_valid), .DMEM_VALID(dmem_valid),
    .IMEM_REQ(imem_req), .IR_WRITE(ir_write),
    .PC_WRITE(pc_write), .PC_SOURCE(pc_source),
    .DMEM_RDEN(dmem_rden), .DMEM_WE(dmem_we),
    .RF_WE(rf_we), .CSR_WE(csr_we),
    .TRAP_TAKEN(trap_taken), .CAUSE(cause)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, ir_write, pc_write, pc_source,
                dmem_rden, dmem_we, rf_we, csr_we,
                trap_taken, cause};

  task automatic check(string tag, logic [12:0] got,
                       logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ev(
    bit req, bit irw, bit pcw, logic [2:0] src,
    bit rd, bit we, bit rf, bit csr,
    bit trp, logic [1:0] cs);
    return {req, irw, pcw, src, rd, we, rf, csr, trp, cs};
  endfunction

  function automatic logic [12:0] trap_ev(logic [1:0] cs);
    return ev(0, 0, 1, 3'd4, 0, 0, 0, 0, 1, cs);
  endfunction

  task automatic step(string tag, logic iv, logic dv,
                      logic in_i, logic [12:0] exp);
    imem_valid = iv;
    dmem_valid = dv;
    intr       = in_i;
    #1;
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic do_instr(string tag, logic [6:0] op,
                          logic [2:0] f3, bit br,
                          int ilat, int dlat,
                          bit irq, bit en);
    logic [12:0] e;
    bit done, mem, ld;
    opcode   = op;
    funct3   = f3;
    br_taken = br;
    mie      = en;
    if (ilat >= T) begin
      for (int i = 0; i < T; i++)
        step({tag, ".fto"}, 0, rb(), rb(),
             (i == T - 1) ? 13'd0 : ev(1,0,0,0,0,0,0,0,0,0));
      step({tag, ".ftrap"}, rb(), rb(), rb(), trap_ev(2'd3));
      return;
    end
    for (int i = 0; i < ilat; i++)
      step({tag, ".fwait"}, 0, rb(), rb(),
           ev(1,0,0,0,0,0,0,0,0,0));
    step({tag, ".fetch"}, 1, rb(), rb(),
         ev(1,1,0,0,0,0,0,0,0,0));
    done = 0;
    mem  = 0;
    ld   = (op == 7'b0000011);
    e    = '0;
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
        e = ev(0,0,1,3'd0,0,0,1,0,0,0);
        done = 1;
      end
      7'b1101111: begin
        e = ev(0,0,1,3'd3,0,0,1,0,0,0);
        done = 1;
      end
      7'b1100111: begin
        e = ev(0,0,1,3'd1,0,0,1,0,0,0);
        done = 1;
      end
      7'b1100011: begin
        e = ev(0,0,1,br ? 3'd2 : 3'd0,0,0,0,0,0,0);
        done = 1;
      end
      7'b1110011: begin
        if (f3 == 3'b000) e = ev(0,0,1,3'd5,0,0,0,0,0,0);
        else              e = ev(0,0,1,3'd0,0,0,1,1,0,0);
        done = 1;
      end
      7'b0000011: begin
        e = ev(0,0,0,3'd0,1,0,0,0,0,0);
        mem = 1;
      end
      7'b0100011: begin
        e = ev(0,0,0,3'd0,0,1,0,0,0,0);
        mem = 1;
      end
      default: e = '0;
    endcase
    step({tag, ".exec"}, rb(), rb(), done ? irq : rb(), e);
    if (!done && !mem) begin
      step({tag, ".itrap"}, rb(), rb(), rb(), trap_ev(2'd2));
      return;
    end
    if (mem) begin
      e = ev(0,0,0,3'd0,ld,!ld,0,0,0,0);
      if (dlat >= T) begin
        for (int i = 0; i < T; i++)
          step({tag, ".mto"}, rb(), 0, rb(),
               (i == T - 1) ? 13'd0 : e);
        step({tag, ".mtrap"}, rb(), rb(), rb(), trap_ev(2'd3));
        return;
      end
      for (int i = 0; i < dlat; i++)
        step({tag, ".mwait"}, rb(), 0, rb(), e);
      e = ev(0,0,1,3'd0,ld,!ld,ld,0,0,0);
      step({tag, ".mdone"}, rb(), 1, irq, e);
    end
    if (irq && en)
      step({tag, ".irq"}, rb(), rb(), rb(), trap_ev(2'd1));
  endtask

  logic [6:0] ops [11];

  initial begin
    ops[0]  = 7'b0110011; ops[1]  = 7'b0010011;
    ops[2]  = 7'b0110111; ops[3]  = 7'b0010111;
    ops[4]  = 7'b1101111; ops[5]  = 7'b1100111;
    ops[6]  = 7'b1100011; ops[7]  = 7'b1110011;
    ops[8]  = 7'b0000011; ops[9]  = 7'b0100011;
    ops[10] = 7'b0000000;

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step("reset", rb(), rb(), rb(), 13'd0);
    rst_n = 1'b1;

    do_instr("opimm",  7'b0010011, 3'b000, 0, 1, 0, 0, 0);
    do_instr("br_tk",  7'b1100011, 3'b000, 1, 0, 0, 0, 0);
    do_instr("br_nt",  7'b1100011, 3'b001, 0, 2, 0, 0, 0);
    do_instr("load4",  7'b0000011, 3'b010, 0, 0, 4, 0, 0);
    do_instr("add_irq", 7'b0110011, 3'b000, 0, 1, 0, 1, 1);
    do_instr("add_mie0", 7'b0110011, 3'b000, 0, 1, 0, 1, 0);
    do_instr("fto",    7'b0110011, 3'b000, 0, T, 0, 0, 0);
    do_instr("fedge",  7'b0110011, 3'b000, 0, T - 1, 0, 0, 0);
    do_instr("illegal", 7'b0000000, 3'b000, 0, 0, 0, 1, 1);
    do_instr("mret",   7'b1110011, 3'b000, 0, 0, 0, 0, 0);
    do_instr("mret_irq", 7'b1110011, 3'b000, 0, 0, 0, 1, 1);
    do_instr("csr",    7'b1110011, 3'b001, 0, 0, 0, 0, 1);
    do_instr("st_to",  7'b0100011, 3'b010, 0, 0, T, 0, 0);
    do_instr("st_edge", 7'b0100011, 3'b010, 0, 0, T - 1, 1, 1);
    do_instr("jal",    7'b1101111, 3'b000, 0, 0, 0, 0, 0);
    do_instr("jalr",   7'b1100111, 3'b000, 0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int k, il, dl;
      k  = $urandom_range(0, 10);
      il = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, 3);
      dl = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, 5);
      do_instr("rnd", ops[k], 3'($urandom_range(0, 7)), rb(),
               il, dl, rb(), rb());
    end

    opcode   = 7'b0000011;
    funct3   = 3'b010;
    mie      = 1'b0;
    step("rst.fetch", 1, 0, 0, ev(1,1,0,0,0,0,0,0,0,0));
    step("rst.exec", 0, 0, 0, ev(0,0,0,0,1,0,0,0,0,0));
    step("rst.mwait", 0, 0, 0, ev(0,0,0,0,1,0,0,0,0,0));
    rst_n = 1'b0;
    step("rst.low", 0, 1, 0, 13'd0);
    step("rst.low2", 1, 1, 0, 13'd0);
    rst_n = 1'b1;
    do_instr("rst.after", 7'b0110011, 3'b000, 0, T - 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
